mux2x1_rr_arbiter: RTL and testbench

//  Round-robin arbiter and output register stage in front of mux2x1.
//  Two valid/ready sources compete for one valid/ready sink. The block owns the select line S.
//  It builds the data path from DATA_W bitwise mux2x1 instances: i0=req0_data[k], i1=req1_data[k], S=sel.
//  It registers the chosen beat toward the downstream consumer.

---
 rtl/mux2x1_rr_arbiter_if.sv | 28 ++
 rtl/mux2x1_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux2x1_rr_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mux2x1_rr_arbiter_if.sv
// Handshake bundle between two requesting sources, the round-robin arbiter and
// the single downstream sink. The arbiter connects through the slave modport.
interface mux2x1_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    // Valid/ready: a beat moves on a rising edge where valid & ready are both 1;
    // the producer holds valid and data stable until that edge, ready may toggle freely.
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, sel, out_valid, out_data
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter with burst limit driving the select of a bitwise mux2x1
// data path, followed by a single registered output stage toward the sink.
module mux2x1 (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y
);
    assign y = s ? i1 : i0;
endmodule

module mux2x1_rr_arbiter #(
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = 4,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux2x1_rr_arbiter_if.slave    bus,
    output logic [1:0]            dbg_state,
    output logic [CNT_W-1:0]      dbg_burst_cnt
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W:0] BURST_LAST = (CNT_W + 1)'(MAX_BURST);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [DATA_W-1:0]  mux_data;
    logic [CNT_W:0]     cnt_inc;
    logic               grant0, grant1, space, load, burst_done;

    assign grant0 = (state_q == GRANT0);
    assign grant1 = (state_q == GRANT1);
    assign space  = !out_valid_q || bus.out_ready;

    // Readies are forced low while reset is asserted, whatever state is held.
    assign bus.req0_ready = rst_n && grant0 && space;
    assign bus.req1_ready = rst_n && grant1 && space;
    assign bus.sel        = grant1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;

    assign load = (grant0 && bus.req0_valid && bus.req0_ready) ||
                  (grant1 && bus.req1_valid && bus.req1_ready);

    assign cnt_inc    = {1'b0, burst_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign burst_done = load && (cnt_inc == BURST_LAST);

    for (genvar k = 0; k < DATA_W; k++) begin : g_mux
        mux2x1 u_mux (
            .i0 (bus.req0_data[k]),
            .i1 (bus.req1_data[k]),
            .s  (bus.sel),
            .y  (mux_data[k])
        );
    end

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (bus.req0_valid) begin
                    state_d = GRANT0;
                end else if (bus.req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!bus.req0_valid) begin
                    state_d      = bus.req1_valid ? GRANT1 : IDLE;
                    burst_cnt_d  = '0;
                    last_grant_d = 1'b0;
                end else if (burst_done) begin
                    // A full burst only hands over when the other side is waiting.
                    burst_cnt_d = '0;
                    if (bus.req1_valid) begin
                        state_d      = GRANT1;
                        last_grant_d = 1'b0;
                    end
                end else if (load) begin
                    burst_cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            GRANT1: begin
                if (!bus.req1_valid) begin
                    state_d      = bus.req0_valid ? GRANT0 : IDLE;
                    burst_cnt_d  = '0;
                    last_grant_d = 1'b1;
                end else if (burst_done) begin
                    burst_cnt_d = '0;
                    if (bus.req0_valid) begin
                        state_d      = GRANT0;
                        last_grant_d = 1'b1;
                    end
                end else if (load) begin
                    burst_cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
            if (load) begin
                out_data_q  <= mux_data;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign dbg_state     = state_q;
    assign dbg_burst_cnt = burst_cnt_q;
endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Directed bench for mux2x1_rr_arbiter: a per-cycle vector table for reset,
// single-source, drop-out and reset-mid-op, plus streaming contention/stall sequences.
module tb_mux2x1_rr_arbiter;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_burst_cnt;
    int               tests_run = 0;
    int               tests_failed = 0;

    mux2x1_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mux2x1_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .dbg_state     (dbg_state),
        .dbg_burst_cnt (dbg_burst_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        ordy;
        logic        e_r0;
        logic        e_r1;
        logic        e_sel;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_st;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst, input logic v0, input logic [7:0] d0,
                           input logic v1, input logic [7:0] d1, input logic ordy,
                           input logic e_r0, input logic e_r1, input logic e_sel,
                           input logic e_ov, input logic [7:0] e_od, input logic [1:0] e_st,
                           input int e_cnt);
        vec_t v;
        v.rst_n = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_sel = e_sel; v.e_ov = e_ov;
        v.e_od = e_od; v.e_st = e_st; v.e_cnt = CNT_W'(e_cnt);
        vecs.push_back(v);
    endtask

    // driver: apply inputs right after the edge
    task automatic drive(input logic rst, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic ordy);
        rst_n          = rst;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.out_ready  = ordy;
    endtask

    function automatic logic [7:0] exp_beat(input int k);
        int grp;
        int idx;
        int pair;
        grp  = k / MAX_BURST;
        idx  = k % MAX_BURST;
        pair = grp / 2;
        if (grp % 2 == 0) return 8'(8'h80 + pair * MAX_BURST + idx);
        return 8'(8'hC0 + pair * MAX_BURST + idx);
    endfunction

    // Both sources stream continuously; scoreboard holds the round-robin beat order.
    task automatic run_stream(input int n_beats, input int stall_start, input int stall_len);
        logic [7:0]       exp_q[$];
        int               n0;
        int               n1;
        int               got;
        bit               started;
        bit               stall;
        logic [7:0]       held_data;
        logic [CNT_W-1:0] held_cnt;
        logic [1:0]       held_st;
        n0 = 0; n1 = 0; got = 0; started = 0;
        held_data = '0; held_cnt = '0; held_st = '0;
        for (int k = 0; k < n_beats; k++) exp_q.push_back(exp_beat(k));
        for (int cyc = 0; cyc < 200 && got < n_beats; cyc++) begin
            stall = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            drive(1'b1, 1'b1, 8'(8'h80 + n0), 1'b1, 8'(8'hC0 + n1), !stall);
            @(negedge clk);
            if (started) check("stream_no_gap", bus.out_valid, 1'b1);
            if (bus.out_valid) started = 1;
            if (stall) begin
                check("stall_req0_ready", bus.req0_ready, 1'b0);
                check("stall_req1_ready", bus.req1_ready, 1'b0);
                if (cyc == stall_start) begin
                    held_data = bus.out_data;
                    held_cnt  = dbg_burst_cnt;
                    held_st   = dbg_state;
                end else begin
                    check("stall_out_data", bus.out_data, held_data);
                    check("stall_burst_cnt", dbg_burst_cnt, held_cnt);
                    check("stall_state", dbg_state, held_st);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                check("stream_beat", bus.out_data, exp_q.pop_front());
                got++;
            end
            if (bus.req0_valid && bus.req0_ready) n0++;
            if (bus.req1_valid && bus.req1_ready) n1++;
            @(posedge clk);
            #1;
        end
        check("stream_beats_received", got, n_beats);
    endtask

    initial begin
        // reset reaches a defined state before the table starts
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // rst  v0 d0     v1 d1     ordy | r0 r1 sel ov od     state    cnt
        add_vec(0, 1, 8'hA5, 1, 8'h3C, 0,  0, 0, 0, 0, 8'h00, ST_IDLE, 0);
        add_vec(0, 0, 8'h5A, 1, 8'hC3, 1,  0, 0, 0, 0, 8'h00, ST_IDLE, 0);
        // single source stream 0x11..0x16
        add_vec(1, 1, 8'h11, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00, ST_IDLE, 0);
        add_vec(1, 1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 0, 8'h00, ST_G0,   0);
        add_vec(1, 1, 8'h12, 0, 8'h00, 1,  1, 0, 0, 1, 8'h11, ST_G0,   1);
        add_vec(1, 1, 8'h13, 0, 8'h00, 1,  1, 0, 0, 1, 8'h12, ST_G0,   2);
        add_vec(1, 1, 8'h14, 0, 8'h00, 1,  1, 0, 0, 1, 8'h13, ST_G0,   3);
        add_vec(1, 1, 8'h15, 0, 8'h00, 1,  1, 0, 0, 1, 8'h14, ST_G0,   0);
        add_vec(1, 1, 8'h16, 0, 8'h00, 1,  1, 0, 0, 1, 8'h15, ST_G0,   1);
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 8'h16, ST_G0,   2);
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'h16, ST_IDLE, 0);
        // source 0 drops out after two beats while source 1 waits
        add_vec(1, 1, 8'h21, 0, 8'h00, 1,  0, 0, 0, 0, 8'h16, ST_IDLE, 0);
        add_vec(1, 1, 8'h21, 1, 8'h31, 1,  1, 0, 0, 0, 8'h16, ST_G0,   0);
        add_vec(1, 1, 8'h22, 1, 8'h31, 1,  1, 0, 0, 1, 8'h21, ST_G0,   1);
        add_vec(1, 0, 8'h00, 1, 8'h31, 1,  1, 0, 0, 1, 8'h22, ST_G0,   2);
        add_vec(1, 0, 8'h00, 1, 8'h31, 1,  0, 1, 1, 0, 8'h22, ST_G1,   0);
        add_vec(1, 0, 8'h00, 1, 8'h32, 1,  0, 1, 1, 1, 8'h31, ST_G1,   1);
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  0, 1, 1, 1, 8'h32, ST_G1,   2);
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'h32, ST_IDLE, 0);
        // reset while a beat is held, then a tie goes to source 0
        add_vec(1, 0, 8'h00, 1, 8'h41, 0,  0, 0, 0, 0, 8'h32, ST_IDLE, 0);
        add_vec(1, 0, 8'h00, 1, 8'h41, 0,  0, 1, 1, 0, 8'h32, ST_G1,   0);
        add_vec(0, 0, 8'h00, 1, 8'h42, 0,  0, 0, 1, 1, 8'h41, ST_G1,   1);
        add_vec(1, 1, 8'h51, 1, 8'h61, 1,  0, 0, 0, 0, 8'h00, ST_IDLE, 0);
        add_vec(1, 1, 8'h51, 1, 8'h61, 1,  1, 0, 0, 0, 8'h00, ST_G0,   0);
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 8'h51, ST_G0,   1);
        add_vec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'h51, ST_IDLE, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("row%0d_req0_ready", i), bus.req0_ready, vecs[i].e_r0);
            check($sformatf("row%0d_req1_ready", i), bus.req1_ready, vecs[i].e_r1);
            check($sformatf("row%0d_sel", i), bus.sel, vecs[i].e_sel);
            check($sformatf("row%0d_out_valid", i), bus.out_valid, vecs[i].e_ov);
            check($sformatf("row%0d_out_data", i), bus.out_data, vecs[i].e_od);
            check($sformatf("row%0d_state", i), dbg_state, vecs[i].e_st);
            check($sformatf("row%0d_burst_cnt", i), dbg_burst_cnt, vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // contention: 4 beats per source, alternating, no idle cycle
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        run_stream(16, 1000, 0);

        // backpressure for 5 cycles in the middle of a source-0 burst
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        run_stream(12, 3, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
